// File: rtl/mult8_lock_pkg.sv
// Shared definitions for the key-locked 8x8 multiplier front end.
package mult8_lock_pkg;

   localparam int KEY_W = 32;
   localparam int OP_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      ARMED = 2'd2
   } feeder_state_e;

endpackage

// File: rtl/mult8_key_shifter.sv
// Serial key shift register with a saturating bit counter; reports when the
// key will be complete after the current cycle's shift.
module mult8_key_shifter
   import mult8_lock_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             shift_i,
   input  logic             bit_i,
   output logic [KEY_W-1:0] sr_next_o,
   output logic             full_next_o
);

   localparam int CW = $clog2(KEY_W + 1);

   logic [KEY_W-1:0] sr_q, sr_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   // Counter stops at KEY_W so a complete key is held until it is committed.
   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (clear_i) begin
         sr_d  = '0;
         cnt_d = '0;
      end else if (shift_i && (cnt_q != CW'(KEY_W))) begin
         sr_d  = {sr_q[KEY_W-2:0], bit_i};
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign sr_next_o   = sr_d;
   assign full_next_o = (cnt_d == CW'(KEY_W));

   always_ff @(posedge clk) begin
      if (rst) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mult8_key_operand_feeder.sv
// Front end of the key-locked multiplier: loads the key serially and issues
// operand pairs to the core only while a complete key is held.
module mult8_key_operand_feeder
   import mult8_lock_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             key_start_i,
   input  logic             key_shift_i,
   input  logic             key_bit_i,
   output logic             key_valid_o,
   output logic [KEY_W-1:0] key_o,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [OP_W-1:0]  op1_in_i,
   input  logic [OP_W-1:0]  op2_in_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [OP_W-1:0]  op1_o,
   output logic [OP_W-1:0]  op2_o,
   output logic [CNT_W-1:0] op_count_o
);

   feeder_state_e    state_q, state_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic             out_valid_q, out_valid_d;
   logic [OP_W-1:0]  op1_q, op1_d;
   logic [OP_W-1:0]  op2_q, op2_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [KEY_W-1:0] sr_next;
   logic             full_next;
   logic             shift_en;
   logic             stall;
   logic             commit;
   logic             accept;

   assign shift_en = (state_q == LOAD) && key_shift_i && !key_start_i;
   assign stall    = out_valid_q && !out_ready_i;

   mult8_key_shifter u_shifter (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (key_start_i),
      .shift_i     (shift_en),
      .bit_i       (key_bit_i),
      .sr_next_o   (sr_next),
      .full_next_o (full_next)
   );

   // A finished key is committed only when no stalled product is still
   // relying on the old key; otherwise the commit waits in LOAD.
   always_comb begin
      state_d = state_q;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (key_start_i) state_d = LOAD;
         end
         LOAD: begin
            if (key_start_i) begin
               state_d = LOAD;
            end else if (full_next && !stall) begin
               state_d = ARMED;
               commit  = 1'b1;
            end
         end
         ARMED: begin
            if (key_start_i) state_d = LOAD;
         end
         default: state_d = IDLE;
      endcase
   end

   assign key_d = commit ? sr_next : key_q;

   assign in_ready_o = (state_q == ARMED) && !key_start_i && (!out_valid_q || out_ready_i);
   assign accept     = in_valid_i && in_ready_o;

   always_comb begin
      out_valid_d = out_valid_q;
      op1_d       = op1_q;
      op2_d       = op2_q;
      count_d     = count_q;
      if (accept) begin
         out_valid_d = 1'b1;
         op1_d       = op1_in_i;
         op2_d       = op2_in_i;
         count_d     = count_q + 1'b1;
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         key_q       <= '0;
         out_valid_q <= 1'b0;
         op1_q       <= '0;
         op2_q       <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         out_valid_q <= out_valid_d;
         op1_q       <= op1_d;
         op2_q       <= op2_d;
         count_q     <= count_d;
      end
   end

   assign key_valid_o = (state_q == ARMED);
   assign key_o       = key_q;
   assign out_valid_o = out_valid_q;
   assign op1_o       = op1_q;
   assign op2_o       = op2_q;
   assign op_count_o  = count_q;

endmodule

// File: tb/tb_mult8_key_operand_feeder.sv
// Directed bench for the key/operand feeder.
module tb_mult8_key_operand_feeder;

   logic        clk;
   logic        rst;
   logic        key_start_i;
   logic        key_shift_i;
   logic        key_bit_i;
   logic        key_valid_o;
   logic [31:0] key_o;
   logic        in_valid_i;
   logic        in_ready_o;
   logic [7:0]  op1_in_i;
   logic [7:0]  op2_in_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [7:0]  op1_o;
   logic [7:0]  op2_o;
   logic [15:0] op_count_o;

   int tests = 0;
   int fails = 0;

   localparam logic [31:0] K1 = 32'hA5C3_0F1E;
   localparam logic [31:0] K2 = 32'h1234_5678;
   localparam logic [31:0] K3 = 32'hDEAD_BEEF;

   mult8_key_operand_feeder #(.CNT_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .key_start_i (key_start_i),
      .key_shift_i (key_shift_i),
      .key_bit_i   (key_bit_i),
      .key_valid_o (key_valid_o),
      .key_o       (key_o),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .op1_in_i    (op1_in_i),
      .op2_in_i    (op2_in_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .op1_o       (op1_o),
      .op2_o       (op2_o),
      .op_count_o  (op_count_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".key"},   key_o, 32'h0);
      chk({tag, ".kvld"},  {31'b0, key_valid_o}, 32'h0);
      chk({tag, ".ovld"},  {31'b0, out_valid_o}, 32'h0);
      chk({tag, ".op1"},   {24'b0, op1_o}, 32'h0);
      chk({tag, ".op2"},   {24'b0, op2_o}, 32'h0);
      chk({tag, ".count"}, {16'b0, op_count_o}, 32'h0);
   endtask

   // Shifts bits hi..lo of k MSB first; before every edge the old key must
   // still be presented whole and operands must be blocked.
   task automatic shift_bits(input string tag, input logic [31:0] k, input int hi,
                             input int lo, input logic [31:0] old_key);
      for (int i = hi; i >= lo; i--) begin
         key_shift_i = 1'b1;
         key_bit_i   = k[i];
         #1;
         chk({tag, ".rdy"},  {31'b0, in_ready_o}, 32'h0);
         chk({tag, ".kvld"}, {31'b0, key_valid_o}, 32'h0);
         chk({tag, ".key"},  key_o, old_key);
         step();
      end
      key_shift_i = 1'b0;
      key_bit_i   = 1'b0;
   endtask

   task automatic pulse_start();
      key_start_i = 1'b1;
      step();
      key_start_i = 1'b0;
   endtask

   initial begin
      rst = 1'b1; key_start_i = 1'b0; key_shift_i = 1'b0; key_bit_i = 1'b0;
      in_valid_i = 1'b0; op1_in_i = '0; op2_in_i = '0; out_ready_i = 1'b0;

      // 1: reset, operands refused without a key
      step(); step();
      rst = 1'b0;
      chk_reset("rst");
      in_valid_i = 1'b1; op1_in_i = 8'd1; op2_in_i = 8'd2;
      for (int c = 0; c < 10; c++) begin
         #1;
         chk("nokey.rdy", {31'b0, in_ready_o}, 32'h0);
         step();
         chk("nokey.ovld", {31'b0, out_valid_o}, 32'h0);
         chk("nokey.count", {16'b0, op_count_o}, 32'h0);
      end
      in_valid_i = 1'b0;

      // 2: first key load
      pulse_start();
      shift_bits("load1", K1, 31, 0, 32'h0);
      chk("load1.key_o", key_o, K1);
      chk("load1.kvld", {31'b0, key_valid_o}, 32'h1);

      // 3: back-to-back stream
      out_ready_i = 1'b1; in_valid_i = 1'b1;
      op1_in_i = 8'd3; op2_in_i = 8'd5; #1;
      chk("strm.rdy", {31'b0, in_ready_o}, 32'h1);
      chk("strm.ovld0", {31'b0, out_valid_o}, 32'h0);
      step();
      chk("strm.p0", {16'b0, op1_o, op2_o}, 32'h0000_0305);
      chk("strm.ovld1", {31'b0, out_valid_o}, 32'h1);
      op1_in_i = 8'd255; op2_in_i = 8'd255; step();
      chk("strm.p1", {16'b0, op1_o, op2_o}, 32'h0000_FFFF);
      op1_in_i = 8'd0; op2_in_i = 8'd7; step();
      chk("strm.p2", {16'b0, op1_o, op2_o}, 32'h0000_0007);
      chk("strm.count", {16'b0, op_count_o}, 32'd3);

      // 4: backpressure
      op1_in_i = 8'd12; op2_in_i = 8'd34; step();
      chk("bp.p", {16'b0, op1_o, op2_o}, 32'h0000_0C22);
      chk("bp.count4", {16'b0, op_count_o}, 32'd4);
      out_ready_i = 1'b0; op1_in_i = 8'd56; op2_in_i = 8'd78; #1;
      chk("bp.rdy0", {31'b0, in_ready_o}, 32'h0);
      for (int c = 0; c < 2; c++) begin
         step();
         chk("bp.hold", {16'b0, op1_o, op2_o}, 32'h0000_0C22);
         chk("bp.hvld", {31'b0, out_valid_o}, 32'h1);
         chk("bp.hcnt", {16'b0, op_count_o}, 32'd4);
      end
      out_ready_i = 1'b1; #1;
      chk("bp.rdy1", {31'b0, in_ready_o}, 32'h1);
      step();
      chk("bp.next", {16'b0, op1_o, op2_o}, 32'h0000_384E);
      chk("bp.count5", {16'b0, op_count_o}, 32'd5);
      in_valid_i = 1'b0; out_ready_i = 1'b0; step();
      chk("bp.pend", {31'b0, out_valid_o}, 32'h1);

      // 5: reload from ARMED with a pending pair
      key_start_i = 1'b1; #1;
      chk("rl.rdy_start", {31'b0, in_ready_o}, 32'h0);
      step();
      key_start_i = 1'b0;
      chk("rl.kvld", {31'b0, key_valid_o}, 32'h0);
      chk("rl.pend", {31'b0, out_valid_o}, 32'h1);
      chk("rl.pop", {16'b0, op1_o, op2_o}, 32'h0000_384E);
      in_valid_i = 1'b1; op1_in_i = 8'd99; op2_in_i = 8'd98;
      shift_bits("rl.a", K2, 31, 22, K1);
      chk("rl.stillpend", {31'b0, out_valid_o}, 32'h1);
      out_ready_i = 1'b1;
      shift_bits("rl.b", K2, 21, 0, K1);
      chk("rl.key_o", key_o, K2);
      chk("rl.kvld1", {31'b0, key_valid_o}, 32'h1);
      chk("rl.ovld", {31'b0, out_valid_o}, 32'h0);
      chk("rl.opkeep", {16'b0, op1_o, op2_o}, 32'h0000_384E);
      chk("rl.count", {16'b0, op_count_o}, 32'd5);
      op1_in_i = 8'd9; op2_in_i = 8'd9; step();
      chk("rl.newop", {16'b0, op1_o, op2_o}, 32'h0000_0909);
      chk("rl.count6", {16'b0, op_count_o}, 32'd6);
      in_valid_i = 1'b0; step();
      chk("rl.drain", {31'b0, out_valid_o}, 32'h0);

      // 6: restart mid-load, then reset mid-load with a pending pair
      pulse_start();
      shift_bits("rs.a", K3, 31, 15, K2);
      pulse_start();
      shift_bits("rs.b", K3, 31, 0, K2);
      chk("rs.key_o", key_o, K3);
      chk("rs.kvld", {31'b0, key_valid_o}, 32'h1);
      out_ready_i = 1'b0; in_valid_i = 1'b1; op1_in_i = 8'd11; op2_in_i = 8'd22;
      step();
      in_valid_i = 1'b0;
      chk("rs.pend", {31'b0, out_valid_o}, 32'h1);
      chk("rs.count7", {16'b0, op_count_o}, 32'd7);
      pulse_start();
      shift_bits("rs.c", K2, 31, 13, K3);
      rst = 1'b1; key_shift_i = 1'b1; key_bit_i = K2[12];
      step();
      rst = 1'b0; key_shift_i = 1'b0; key_bit_i = 1'b0;
      chk_reset("rs.rst");
      shift_bits("idle", 32'hFFFF_FFFF, 31, 0, 32'h0);
      chk("idle.key_o", key_o, 32'h0);
      chk("idle.kvld", {31'b0, key_valid_o}, 32'h0);
      in_valid_i = 1'b1; #1;
      chk("idle.rdy", {31'b0, in_ready_o}, 32'h0);
      step();
      in_valid_i = 1'b0;
      chk("idle.ovld", {31'b0, out_valid_o}, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
